mmio_io_ctrl: RTL and testbench

- Parametrised memory-mapped I/O controller behind the LSU.
- Decodes the 4 KiB I/O region and holds the output registers: LEDR, LEDG, NUM_HEX seven-segment digits and LCD.
- Provides byte-masked stores and registered loads with a valid strobe.
- Synchronises and debounces switches and buttons, and keeps a sticky button-press capture register that raises an interrupt.

---
 rtl/mmio_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/mmio_io_ctrl.sv | 154 +++++++++++++++
 tb/tb_mmio_io_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the memory-mapped I/O controller.
package mmio_pkg;

  // Register offsets within the 4 KiB I/O region.
  localparam logic [11:0] OFF_LEDR   = 12'h000;
  localparam logic [11:0] OFF_LEDG   = 12'h010;
  localparam logic [11:0] OFF_HEX0   = 12'h020;
  localparam logic [11:0] OFF_LCD    = 12'h030;
  localparam logic [11:0] OFF_SW     = 12'h800;
  localparam logic [11:0] OFF_BTN    = 12'h810;
  localparam logic [11:0] OFF_BTNCAP = 12'h814;

  // Active-low segments: all ones turns a digit off.
  localparam logic [6:0] HEX_BLANK = 7'h7F;

  // Replace the bytes of old_val selected by mask with those of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser followed by a stability counter.
// The level flips only after the synchronised input has disagreed with it
// on DEB_CYCLES consecutive edges; o_rise marks the edge of a 0->1 flip.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic sync1, sync2, level_q, differ, done;
  logic [CNT_W-1:0] cnt_q;

  assign differ  = sync2 ^ level_q;
  assign done    = differ && (cnt_q == CNT_MAX);
  assign o_level = level_q;
  assign o_rise  = done && !level_q;

  // Synchronise, count disagreeing cycles, flip the level when stable long enough.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1 <= i_async;
      sync2 <= sync1;
      if (!differ) begin
        cnt_q <= '0;
      end else if (done) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: output registers, switch/button inputs,
// sticky button capture with interrupt.
// Bus handshake: a store commits at the edge where i_wren=1; a load issued
// at edge N returns o_ld_data qualified by a one-cycle o_ld_valid after N,
// and always sees the register state from before any same-cycle store.
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = 32'h0000_7000,
  parameter int          LEDR_W     = 17,
  parameter int          LEDG_W     = 8,
  parameter int          NUM_HEX    = 8,
  parameter int          SW_W       = 18,
  parameter int          BTN_W      = 4,
  parameter int          DEB_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_st_data,
  input  logic                 i_wren,
  input  logic [3:0]           i_bmask,
  input  logic                 i_rden,
  output logic [31:0]          o_ld_data,
  output logic                 o_ld_valid,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd,
  input  logic [SW_W-1:0]      i_io_sw,
  input  logic [BTN_W-1:0]     i_io_btn,
  output logic                 o_btn_irq
);
  localparam int HEX_WORDS = NUM_HEX / 4;

  logic [9:0]        widx;
  logic              hit, wr, unused_addr;
  logic [LEDR_W-1:0] ledr_q;
  logic [LEDG_W-1:0] ledg_q;
  logic [6:0]        hex_q [NUM_HEX];
  logic [31:0]       lcd_q;
  logic [SW_W-1:0]   sw_s1, sw_s2;
  logic [BTN_W-1:0]  btn_level, btn_rise, cap_q, cap_clr, cap_next;
  logic [31:0]       ledr_x, ledg_x, sw_x, lvl_x, cap_x, rd_mux;
  logic [31:0]       hex_w [HEX_WORDS];

  assign widx        = i_addr[11:2];
  assign hit         = (i_addr[31:12] == IO_BASE[31:12]);
  assign wr          = i_wren && hit;
  assign unused_addr = ^i_addr[1:0];

  // Zero-extended 32-bit views of every readable register.
  always_comb begin
    ledr_x = '0;
    ledr_x[LEDR_W-1:0] = ledr_q;
    ledg_x = '0;
    ledg_x[LEDG_W-1:0] = ledg_q;
    sw_x = '0;
    sw_x[SW_W-1:0] = sw_s2;
    lvl_x = '0;
    lvl_x[BTN_W-1:0] = btn_level;
    cap_x = '0;
    cap_x[BTN_W-1:0] = cap_q;
    for (int j = 0; j < HEX_WORDS; j++) begin
      hex_w[j] = '0;
      for (int b = 0; b < 4; b++) hex_w[j][8*b +: 7] = hex_q[4*j+b];
    end
  end

  // Read decode; unmapped offsets fall through to zero.
  always_comb begin
    rd_mux = '0;
    if (widx == OFF_LEDR[11:2])   rd_mux = ledr_x;
    if (widx == OFF_LEDG[11:2])   rd_mux = ledg_x;
    if (widx == OFF_LCD[11:2])    rd_mux = lcd_q;
    if (widx == OFF_SW[11:2])     rd_mux = sw_x;
    if (widx == OFF_BTN[11:2])    rd_mux = lvl_x;
    if (widx == OFF_BTNCAP[11:2]) rd_mux = cap_x;
    for (int j = 0; j < HEX_WORDS; j++) begin
      if (widx == OFF_HEX0[11:2] + 10'(j)) rd_mux = hex_w[j];
    end
  end

  // Byte-masked stores into the output registers; bit 7 of each HEX byte is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= HEX_BLANK;
    end else if (wr) begin
      if (widx == OFF_LEDR[11:2]) ledr_q <= LEDR_W'(merge_bytes(ledr_x, i_st_data, i_bmask));
      if (widx == OFF_LEDG[11:2]) ledg_q <= LEDG_W'(merge_bytes(ledg_x, i_st_data, i_bmask));
      if (widx == OFF_LCD[11:2])  lcd_q  <= merge_bytes(lcd_q, i_st_data, i_bmask);
      for (int j = 0; j < HEX_WORDS; j++) begin
        for (int b = 0; b < 4; b++) begin
          if (widx == OFF_HEX0[11:2] + 10'(j) && i_bmask[b]) hex_q[4*j+b] <= i_st_data[8*b +: 7];
        end
      end
    end
  end

  // Write-one-to-clear on the capture register; a same-cycle rise wins.
  assign cap_clr  = (wr && widx == OFF_BTNCAP[11:2]) ?
                    BTN_W'(merge_bytes(32'h0, i_st_data, i_bmask)) : '0;
  assign cap_next = (cap_q & ~cap_clr) | btn_rise;

  // Switch synchroniser, capture register and interrupt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      cap_q     <= '0;
      o_btn_irq <= 1'b0;
    end else begin
      sw_s1     <= i_io_sw;
      sw_s2     <= sw_s1;
      cap_q     <= cap_next;
      o_btn_irq <= |cap_next;
    end
  end

  // Registered load response; a miss still answers with zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ld_valid <= 1'b0;
      o_ld_data  <= '0;
    end else begin
      o_ld_valid <= i_rden;
      o_ld_data  <= (i_rden && hit) ? rd_mux : '0;
    end
  end

  for (genvar i = 0; i < BTN_W; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_io_btn[i]),
      .o_level (btn_level[i]),
      .o_rise  (btn_rise[i])
    );
  end

  // Flatten the digit registers onto the segment bus.
  always_comb begin
    o_io_hex = '0;
    for (int k = 0; k < NUM_HEX; k++) o_io_hex[7*k +: 7] = hex_q[k];
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: directed scenarios followed by random bus and
// input traffic, all checked against a cycle-level reference model.
module tb_mmio_io_ctrl;
  localparam int LEDR_W = 17, LEDG_W = 8, NUM_HEX = 8, SW_W = 18, BTN_W = 4, DEB = 16;
  localparam int HW = NUM_HEX / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]          addr, st_data, ld_data, lcd;
  logic                 wren, rden, ld_valid, irq;
  logic [3:0]           bmask;
  logic [LEDR_W-1:0]    ledr;
  logic [LEDG_W-1:0]    ledg;
  logic [7*NUM_HEX-1:0] hex;
  logic [SW_W-1:0]      sw;
  logic [BTN_W-1:0]     btn;

  mmio_io_ctrl #(
    .IO_BASE(32'h0000_7000), .LEDR_W(LEDR_W), .LEDG_W(LEDG_W), .NUM_HEX(NUM_HEX),
    .SW_W(SW_W), .BTN_W(BTN_W), .DEB_CYCLES(DEB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_st_data(st_data), .i_wren(wren),
    .i_bmask(bmask), .i_rden(rden), .o_ld_data(ld_data), .o_ld_valid(ld_valid),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd),
    .i_io_sw(sw), .i_io_btn(btn), .o_btn_irq(irq)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural state after each edge, plus the input delay lines.
  logic [31:0] m_ledr, m_ledg, m_lcd, m_sw1, m_sw2, m_cap;
  logic [31:0] m_hexw [HW];
  logic [BTN_W-1:0] m_b1, m_b2, m_lvl;
  int   m_run [BTN_W];   // consecutive cycles the synced input disagreed with the level
  logic m_irq, m_valid;

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
    logic [31:0] m32;
    m32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (o & ~m32) | (n & m32);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [11:0] off;
    if (a[31:12] != 20'h00007) return 32'h0;
    off = {a[11:2], 2'b00};
    if (off >= 12'h020 && off < 12'h020 + 12'(4*HW)) return m_hexw[(off - 12'h020) >> 2];
    case (off)
      12'h000: return m_ledr;
      12'h010: return m_ledg;
      12'h030: return m_lcd;
      12'h800: return m_sw2;
      12'h810: return 32'(m_lvl);
      12'h814: return m_cap;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ledr = 0; m_ledg = 0; m_lcd = 0; m_sw1 = 0; m_sw2 = 0; m_cap = 0;
    for (int j = 0; j < HW; j++) m_hexw[j] = 32'h7F7F7F7F;
    m_b1 = 0; m_b2 = 0; m_lvl = 0;
    for (int i = 0; i < BTN_W; i++) m_run[i] = 0;
    m_irq = 0; m_valid = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [31:0] clr, rose, merged, off;
    clr = 0; rose = 0;
    if (rden) exp_q.push_back(m_read(addr));   // pre-store view
    m_valid = rden;
    if (wren && addr[31:12] == 20'h00007) begin
      off = {20'h0, addr[11:2], 2'b00};
      case (off)
        32'h000: m_ledr = m_merge(m_ledr, st_data, bmask) & 32'h0001FFFF;
        32'h010: m_ledg = m_merge(m_ledg, st_data, bmask) & 32'h000000FF;
        32'h030: m_lcd  = m_merge(m_lcd, st_data, bmask);
        32'h814: clr    = m_merge(32'h0, st_data, bmask) & 32'hF;
        default: begin
          if (off >= 32'h020 && off < 32'h020 + 32'(4*HW)) begin
            merged = m_merge(m_hexw[(off - 32'h020) >> 2], st_data, bmask);
            m_hexw[(off - 32'h020) >> 2] = merged & 32'h7F7F7F7F;
          end
        end
      endcase
    end
    for (int i = 0; i < BTN_W; i++) begin
      if (m_b2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          if (m_lvl[i]) rose[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_cap = (m_cap & ~clr) | rose;
    m_irq = (m_cap != 0);
    m_b2 = m_b1; m_b1 = btn;
    m_sw2 = m_sw1; m_sw1 = 32'(sw);
  endtask

  task automatic compare_outputs();
    check("ledr", 32'(ledr), m_ledr);
    check("ledg", 32'(ledg), m_ledg);
    check("lcd", lcd, m_lcd);
    check("irq", 32'(irq), 32'(m_irq));
    check("ld_valid", 32'(ld_valid), 32'(m_valid));
    for (int k = 0; k < NUM_HEX; k++)
      check("hex", 32'(hex[7*k +: 7]), (m_hexw[k/4] >> (8*(k%4))) & 32'h7F);
    if (ld_valid === 1'b1) begin
      if (exp_q.size() == 0) check("ld_spurious", 32'(ld_valid), 32'h0);
      else check("ld_data", ld_data, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic bus(input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    wren = w; rden = r; addr = a; st_data = d; bmask = m;
    tick();
    wren = 0; rden = 0; bmask = 0; addr = 0; st_data = 0;
  endtask

  logic [11:0] offs [0:8] = '{12'h000, 12'h010, 12'h020, 12'h024, 12'h028,
                              12'h030, 12'h800, 12'h810, 12'h814};

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] off;
    logic [19:0] page;
    rst = 1; wren = 0; rden = 0; addr = 0; st_data = 0; bmask = 0; sw = 0; btn = 0;
    repeat (2) tick();
    rst = 0;
    check("rst_hex0", 32'(hex[6:0]), 32'h7F);
    check("rst_hex7", 32'(hex[55:49]), 32'h7F);
    check("rst_ledr", 32'(ledr), 32'h0);
    check("rst_valid", 32'(ld_valid), 32'h0);
    bus(0, 1, 32'h7020, 0, 0);
    check("rst_load", ld_data, 32'h7F7F7F7F);

    // HEX stores
    bus(1, 0, 32'h7020, 32'h03020100, 4'hF);
    check("hex_d0", 32'(hex[6:0]), 32'h00);
    check("hex_d1", 32'(hex[13:7]), 32'h01);
    check("hex_d2", 32'(hex[20:14]), 32'h02);
    check("hex_d3", 32'(hex[27:21]), 32'h03);
    check("hex_d4", 32'(hex[34:28]), 32'h7F);
    for (int i = 0; i < 10; i++) begin
      bus(1, 0, 32'h7020, {4{i[7:0]}}, 4'hF);
      check("hex_loop0", 32'(hex[6:0]), 32'(i));
      check("hex_loop3", 32'(hex[27:21]), 32'(i));
    end

    // byte mask
    bus(1, 0, 32'h7000, 32'hFFFFFFFF, 4'hF);
    bus(1, 0, 32'h7000, 32'h0, 4'b0010);
    check("mask_ledr", 32'(ledr), 32'h100FF);
    bus(0, 1, 32'h7000, 0, 0);
    check("mask_load", ld_data, 32'h000100FF);

    // read during write
    bus(1, 0, 32'h7010, 32'h3C, 4'hF);
    bus(1, 1, 32'h7010, 32'h55, 4'hF);
    check("rdw_old", ld_data, 32'h3C);
    bus(0, 1, 32'h7010, 0, 0);
    check("rdw_new", ld_data, 32'h55);

    // switches and a load outside the mapped registers
    sw = 18'h2AAAA;
    repeat (3) tick();
    bus(0, 1, 32'h7800, 0, 0);
    check("sw_load", ld_data, 32'h0002AAAA);
    bus(0, 1, 32'h7FFC, 0, 0);
    check("unmapped_valid", 32'(ld_valid), 32'h1);
    check("unmapped_data", ld_data, 32'h0);

    // debounce and capture
    for (int i = 0; i < 10; i++) begin
      btn[1] = ~i[0];
      tick();
    end
    btn = 0;
    repeat (3) tick();
    check("bounce_irq", 32'(irq), 32'h0);
    btn = 4'b0010;
    repeat (17) tick();
    check("deb_early", 32'(irq), 32'h0);
    tick();
    check("deb_irq", 32'(irq), 32'h1);
    bus(0, 1, 32'h7814, 0, 0);
    check("cap_load", ld_data, 32'h2);
    bus(1, 0, 32'h7814, 32'h2, 4'hF);
    check("cap_clear", 32'(irq), 32'h0);
    btn = 0;
    repeat (20) tick();
    btn = 4'b0010;
    repeat (17) tick();
    bus(1, 0, 32'h7814, 32'h2, 4'hF);      // clear lands on the rising edge
    check("set_wins", 32'(irq), 32'h1);
    bus(0, 1, 32'h7814, 0, 0);
    check("set_wins_load", ld_data, 32'h2);

    // random traffic, with one reset in the middle
    for (int it = 0; it < 600; it++) begin
      if (it == 300) begin
        rst = 1; rden = 1; tick(); rst = 0; rden = 0;
      end
      if ($urandom_range(0, 15) == 0) sw = SW_W'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        int bi;
        bi = $urandom_range(0, BTN_W - 1);
        btn[bi] = ~btn[bi];
      end
      off = offs[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) off = 12'($urandom);
      page = ($urandom_range(0, 7) == 0) ? 20'h00008 : 20'h00007;
      bus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
          {page, off[11:2], 2'($urandom)}, $urandom, 4'($urandom));
    end
    tick();

    // ---------------- final report ----------------
    check("ld_left", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
